// File: rtl/frame_sync_aligner.sv
// Frame aligner in the fast serial clock domain: locks a frame-phase counter to the VFAT
// start-of-frame line, deserialises each DDR pin into words and tracks loss of lock.
module frame_sync_aligner #(
  parameter int unsigned MXIO      = 8,
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned MXSBITS   = MXIO * WORD_SIZE,
  parameter int unsigned MXSTABLE  = 16,
  parameter int unsigned MXBAD     = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [MXIO-1:0]    d0,
  input  logic [MXIO-1:0]    d1,
  input  logic               start_of_frame,
  input  logic               mask,
  input  logic               clear_i,
  output logic [MXSBITS-1:0] sbits,
  output logic               sbits_valid,
  output logic               locked,
  output logic               sof_unstable,
  output logic [7:0]         unlock_count,
  output logic [1:0]         state
);

  localparam int unsigned FRAME_CYC = WORD_SIZE / 2;
  localparam int unsigned CntW      = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
  localparam int unsigned GoodW     = $clog2(MXSTABLE + 1);
  localparam int unsigned BadW      = $clog2(MXBAD + 1);

  localparam logic [CntW-1:0]  LastPhase = CntW'(FRAME_CYC - 1);
  localparam logic [GoodW-1:0] GoodLast  = GoodW'(MXSTABLE - 1);
  localparam logic [BadW-1:0]  BadLast   = BadW'(MXBAD - 1);

  typedef enum logic [1:0] {
    StSearch = 2'd0,
    StVerify = 2'd1,
    StLocked = 2'd2
  } state_e;

  logic [MXIO-1:0]    r_d0;
  logic [MXIO-1:0]    r_d1;
  logic               r_sof;
  logic               r_sof_h1;
  logic               r_sof_h2;
  logic [CntW-1:0]    r_frame_cnt;
  state_e             r_state;
  logic [GoodW-1:0]   r_good_cnt;
  logic [BadW-1:0]    r_bad_cnt;
  logic [MXSBITS-1:0] r_sreg;
  logic [MXSBITS-1:0] r_sbits;
  logic               r_valid;
  logic               r_unstable;
  logic [7:0]         r_unlock_cnt;

  logic       w_sof_edge;
  logic       w_phase0;
  logic       w_good;
  logic       w_bad;
  logic       w_locked;
  logic       w_unlock;
  logic       w_emit;
  logic [7:0] w_cnt_base;
  logic [7:0] w_cnt_inc;

  // Two low samples must precede the high, so an inverted or swapped SOF never forms an edge.
  assign w_sof_edge = r_sof & ~r_sof_h1 & ~r_sof_h2;
  assign w_phase0   = (r_frame_cnt == '0);
  assign w_good     = w_sof_edge & w_phase0;
  assign w_bad      = w_sof_edge ^ w_phase0;
  assign w_locked   = (r_state == StLocked);
  assign w_unlock   = w_locked & w_bad & (r_bad_cnt == BadLast);
  assign w_emit     = w_locked & ~mask;

  assign w_cnt_base = clear_i ? 8'd0 : r_unlock_cnt;
  assign w_cnt_inc  = (w_cnt_base == 8'hFF) ? 8'hFF : w_cnt_base + 8'd1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_d0     <= '0;
      r_d1     <= '0;
      r_sof    <= 1'b0;
      r_sof_h1 <= 1'b1;
      r_sof_h2 <= 1'b1;
    end else begin
      r_d0     <= d0;
      r_d1     <= d1;
      r_sof    <= start_of_frame;
      r_sof_h1 <= r_sof;
      r_sof_h2 <= r_sof_h1;
    end
  end

  // The earlier bit of each pair lands above the later one, so the first bit ends in the MSB.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sreg <= '0;
    end else begin
      for (int p = 0; p < MXIO; p++) begin
        r_sreg[p*WORD_SIZE +: WORD_SIZE] <=
            {r_sreg[p*WORD_SIZE +: WORD_SIZE-2], r_d0[p], r_d1[p]};
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StSearch;
      r_frame_cnt <= '0;
      r_good_cnt  <= '0;
      r_bad_cnt   <= '0;
    end else begin
      if (r_frame_cnt == LastPhase) begin
        r_frame_cnt <= '0;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end

      unique case (r_state)
        StSearch: begin
          // The edge cycle itself is phase 0.
          if (w_sof_edge) begin
            r_frame_cnt <= CntW'(1);
            r_good_cnt  <= '0;
            r_state     <= StVerify;
          end
        end
        StVerify: begin
          if (w_good) begin
            if (r_good_cnt == GoodLast) begin
              r_bad_cnt <= '0;
              r_state   <= StLocked;
            end else begin
              r_good_cnt <= r_good_cnt + 1'b1;
            end
          end else if (w_bad) begin
            r_state <= StSearch;
          end
        end
        StLocked: begin
          if (w_good) begin
            r_bad_cnt <= '0;
          end else if (w_bad) begin
            if (r_bad_cnt == BadLast) begin
              r_state <= StSearch;
            end else begin
              r_bad_cnt <= r_bad_cnt + 1'b1;
            end
          end
        end
        default: r_state <= StSearch;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_unstable   <= 1'b0;
      r_unlock_cnt <= '0;
    end else if (w_unlock) begin
      r_unstable   <= 1'b1;
      r_unlock_cnt <= w_cnt_inc;
    end else if (clear_i) begin
      r_unstable   <= 1'b0;
      r_unlock_cnt <= '0;
    end
  end

  // At phase 0 the shift register holds the whole previous frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sbits <= '0;
      r_valid <= 1'b0;
    end else if (w_phase0) begin
      r_sbits <= w_emit ? r_sreg : '0;
      r_valid <= w_emit;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign sbits        = r_sbits;
  assign sbits_valid  = r_valid;
  assign locked       = w_locked;
  assign sof_unstable = r_unstable;
  assign unlock_count = r_unlock_cnt;
  assign state        = r_state;

endmodule

// File: tb/tb_frame_sync_aligner.sv
// Directed bench for frame_sync_aligner: lock, inverted SOF, misses, phase jump, mask/clear,
// unlock saturation and asynchronous reset.
module tb_frame_sync_aligner;

  logic        clock;
  logic        reset_n;
  logic [7:0]  d0;
  logic [7:0]  d1;
  logic        start_of_frame;
  logic        mask;
  logic        clear_i;
  logic [63:0] sbits;
  logic        sbits_valid;
  logic        locked;
  logic        sof_unstable;
  logic [7:0]  unlock_count;
  logic [1:0]  state;

  int          n_total;
  int          n_bad;
  logic [7:0]  data_base;
  logic [3:0]  vm;
  logic [63:0] sb;

  frame_sync_aligner #(
    .MXIO      (8),
    .WORD_SIZE (8),
    .MXSTABLE  (4),
    .MXBAD     (2)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .d0             (d0),
    .d1             (d1),
    .start_of_frame (start_of_frame),
    .mask           (mask),
    .clear_i        (clear_i),
    .sbits          (sbits),
    .sbits_valid    (sbits_valid),
    .locked         (locked),
    .sof_unstable   (sof_unstable),
    .unlock_count   (unlock_count),
    .state          (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_sbits(input logic [7:0] base);
    logic [63:0] r;
    for (int p = 0; p < 8; p++) r[8*p +: 8] = base + 8'(p);
    return r;
  endfunction

  // One clock: drive pair number ph of byte data_base+p on every pin p.
  task automatic tick(input logic sof, input int ph, input logic clr);
    logic [7:0] b;
    for (int p = 0; p < 8; p++) begin
      b     = data_base + 8'(p);
      d0[p] = b[7-2*ph];
      d1[p] = b[6-2*ph];
    end
    start_of_frame = sof;
    clear_i        = clr;
    @(posedge clock);
    #1;
  endtask

  // mode: 0 no SOF, 1 normal SOF pulse, 2 inverted SOF. clr_at: tick index carrying clear_i.
  task automatic run_frame(input int mode, input int clr_at);
    logic s;
    for (int k = 0; k < 4; k++) begin
      s = (mode == 1) ? (k == 0) : ((mode == 2) ? (k != 0) : 1'b0);
      tick(s, k, clr_at == k);
      vm[k] = sbits_valid;
    end
    sb = sbits;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 0, 1'b0);
  endtask

  initial begin
    n_total        = 0;
    n_bad          = 0;
    data_base      = 8'hA0;
    d0             = '0;
    d1             = '0;
    start_of_frame = 1'b0;
    mask           = 1'b0;
    clear_i        = 1'b0;
    reset_n        = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    check("rst_sbits", sbits, 64'd0);
    check("rst_valid", 64'(sbits_valid), 64'd0);
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_unstable", 64'(sof_unstable), 64'd0);
    check("rst_count", 64'(unlock_count), 64'd0);
    check("rst_state", 64'(state), 64'd0);
    #9 reset_n = 1'b1;

    // Inverted SOF never produces an edge.
    tick(1'b1, 0, 1'b0);
    for (int f = 0; f < 4; f++) run_frame(2, -1);
    check("inv_state", 64'(state), 64'd0);
    check("inv_valid", 64'(vm), 64'd0);
    check("inv_sbits", sb, 64'd0);

    // Clean lock.
    idle(3);
    for (int f = 0; f < 4; f++) run_frame(1, -1);
    check("lock_verify", 64'(state), 64'd1);
    run_frame(1, -1);
    check("lock_state", 64'(state), 64'd2);
    check("lock_locked", 64'(locked), 64'd1);
    check("lock_f5_valid", 64'(vm), 64'd0);
    run_frame(1, -1);
    check("lock_f6_valid", 64'(vm), 64'b0010);
    check("lock_f6_sbits", sb, exp_sbits(8'hA0));
    run_frame(1, -1);
    check("lock_f7_valid", 64'(vm), 64'b0010);

    // Single misses in LOCKED are forgiven by the next good SOF.
    run_frame(0, -1);
    check("miss_locked", 64'(locked), 64'd1);
    check("miss_valid", 64'(vm), 64'b0010);
    check("miss_sbits", sb, exp_sbits(8'hA0));
    data_base = 8'h30;
    run_frame(1, -1);
    data_base = 8'hC3;
    run_frame(0, -1);
    check("miss2_locked", 64'(locked), 64'd1);
    check("miss2_unstable", 64'(sof_unstable), 64'd0);
    check("miss2_sbits", sb, exp_sbits(8'h30));
    run_frame(1, -1);
    check("f11_sbits", sb, exp_sbits(8'hC3));

    // Phase jump by one clock.
    tick(1'b0, 0, 1'b0);
    run_frame(1, -1);
    check("jump_state", 64'(state), 64'd0);
    check("jump_unstable", 64'(sof_unstable), 64'd1);
    check("jump_count", 64'(unlock_count), 64'd1);
    check("jump_valid", 64'(vm), 64'b0001);
    check("jump_sbits", sb, exp_sbits(8'hC3));
    data_base = 8'h50;
    run_frame(1, -1);
    check("jump_zero_valid", 64'(vm), 64'd0);
    check("jump_zero_sbits", sb, 64'd0);
    for (int f = 0; f < 3; f++) run_frame(1, -1);
    check("relock_verify", 64'(state), 64'd1);
    run_frame(1, -1);
    check("relock_state", 64'(state), 64'd2);
    run_frame(1, -1);
    check("relock_valid", 64'(vm), 64'b0010);
    check("relock_sbits", sb, exp_sbits(8'h50));

    // Mask and clear.
    mask      = 1'b1;
    data_base = 8'h11;
    run_frame(1, -1);
    check("mask_valid", 64'(vm), 64'd0);
    check("mask_sbits", sb, 64'd0);
    check("mask_locked", 64'(locked), 64'd1);
    mask      = 1'b0;
    data_base = 8'h22;
    run_frame(1, -1);
    check("unmask_valid", 64'(vm), 64'b0010);
    check("unmask_sbits", sb, exp_sbits(8'h11));
    run_frame(1, 0);
    check("clr_unstable", 64'(sof_unstable), 64'd0);
    check("clr_count", 64'(unlock_count), 64'd0);
    check("clr_locked", 64'(locked), 64'd1);

    run_frame(0, -1);
    run_frame(0, -1);
    check("unlock1_count", 64'(unlock_count), 64'd1);
    for (int f = 0; f < 5; f++) run_frame(1, -1);
    check("relock2_state", 64'(state), 64'd2);
    run_frame(0, -1);
    run_frame(0, 1);
    check("clr_vs_unlock_count", 64'(unlock_count), 64'd1);
    check("clr_vs_unlock_flag", 64'(sof_unstable), 64'd1);

    for (int i = 0; i < 255; i++) begin
      for (int f = 0; f < 5; f++) run_frame(1, -1);
      run_frame(0, -1);
      run_frame(0, -1);
      if (i == 253) check("count_255", 64'(unlock_count), 64'd255);
    end
    check("count_sat", 64'(unlock_count), 64'd255);
    check("sat_unstable", 64'(sof_unstable), 64'd1);

    // Asynchronous reset in the middle of a locked frame.
    data_base = 8'h5A;
    for (int f = 0; f < 6; f++) run_frame(1, -1);
    check("pre_rst_locked", 64'(locked), 64'd1);
    tick(1'b1, 0, 1'b0);
    tick(1'b0, 1, 1'b0);
    check("pre_rst_valid", 64'(sbits_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_sbits", sbits, 64'd0);
    check("arst_valid", 64'(sbits_valid), 64'd0);
    check("arst_locked", 64'(locked), 64'd0);
    check("arst_unstable", 64'(sof_unstable), 64'd0);
    check("arst_count", 64'(unlock_count), 64'd0);
    check("arst_state", 64'(state), 64'd0);
    #2 reset_n = 1'b1;
    idle(3);
    for (int f = 0; f < 4; f++) run_frame(1, -1);
    check("arst_verify", 64'(state), 64'd1);
    run_frame(1, -1);
    check("arst_relock", 64'(state), 64'd2);
    check("arst_relock_unst", 64'(sof_unstable), 64'd0);
    run_frame(1, -1);
    check("arst_valid_after", 64'(vm), 64'b0010);
    check("arst_sbits_after", sb, exp_sbits(8'h5A));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
